// File: rtl/ps2_keypress_rx.sv
// PS/2 keyboard receiver with scan-code set 2 make/break decoding.
// Presents a level keypress plus keycode/extended for the PIO to poll.
module ps2_keypress_rx #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       extended,
    output logic       keypress,
    output logic       key_valid,
    output logic       frame_err
);
    localparam int FLT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FLT_W-1:0] FLT_MAX = FLT_W'(FILTER_LEN - 1);
    localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic             clk_s1, clk_s2, dat_s1, dat_s2;
    logic             flt_clk;
    logic [FLT_W-1:0] flt_cnt;
    logic             sample_evt, samp_data;
    state_t           state;
    logic [7:0]       shreg;
    logic [2:0]       bit_cnt;
    logic             par_bit;
    logic [WD_W-1:0]  wd_cnt;
    logic             ext_pend, brk_pend;
    logic             flt_flip, stop_ok, stop_bad, timeout;

    // The filter flips on the FILTER_LEN-th consecutive differing sample.
    assign flt_flip = (clk_s2 != flt_clk) && (flt_cnt == FLT_MAX);

    // Frame verdict is formed in the STOP cycle so outputs land one cycle later.
    assign stop_ok  = sample_evt && (state == STOP) && samp_data && (^{shreg, par_bit});
    assign stop_bad = sample_evt && (state == STOP) && !(samp_data && (^{shreg, par_bit}));
    assign timeout  = !sample_evt && (state != IDLE) && (wd_cnt == WD_MAX);

    // Two-flop synchronisers; idle bus level is high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // Glitch filter on the clock; registers a sample event on a filtered fall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flt_clk    <= 1'b1;
            flt_cnt    <= '0;
            sample_evt <= 1'b0;
            samp_data  <= 1'b1;
        end else begin
            sample_evt <= flt_flip && flt_clk;
            samp_data  <= dat_s2;
            if (clk_s2 != flt_clk) begin
                if (flt_flip) begin
                    flt_clk <= clk_s2;
                    flt_cnt <= '0;
                end else begin
                    flt_cnt <= flt_cnt + 1'b1;
                end
            end else begin
                flt_cnt <= '0;
            end
        end
    end

    // Frame receiver FSM with watchdog; a sample event always beats a timeout.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            par_bit <= 1'b0;
            wd_cnt  <= '0;
        end else if (sample_evt) begin
            wd_cnt <= '0;
            case (state)
                IDLE: begin
                    if (!samp_data) begin
                        shreg   <= '0;
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    shreg   <= {samp_data, shreg[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state <= PARITY;
                end
                PARITY: begin
                    par_bit <= samp_data;
                    state   <= STOP;
                end
                default: state <= IDLE;
            endcase
        end else if (state != IDLE) begin
            if (timeout) begin
                state  <= IDLE;
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + 1'b1;
            end
        end else begin
            wd_cnt <= '0;
        end
    end

    // Prefix tracking and make/break decode into the held-key outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            keycode   <= 8'h00;
            extended  <= 1'b0;
            keypress  <= 1'b0;
            key_valid <= 1'b0;
            frame_err <= 1'b0;
            ext_pend  <= 1'b0;
            brk_pend  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            frame_err <= stop_bad || timeout;
            if (stop_bad || timeout) begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end else if (stop_ok) begin
                if (shreg == 8'hE0) begin
                    ext_pend <= 1'b1;
                end else if (shreg == 8'hF0) begin
                    brk_pend <= 1'b1;
                end else begin
                    ext_pend <= 1'b0;
                    brk_pend <= 1'b0;
                    if (!brk_pend) begin
                        keycode   <= shreg;
                        extended  <= ext_pend;
                        keypress  <= 1'b1;
                        key_valid <= 1'b1;
                    end else if (shreg == keycode && ext_pend == extended) begin
                        // Only the break of the held key releases it.
                        keypress  <= 1'b0;
                        key_valid <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_ps2_keypress_rx.sv
// Directed plus randomized frames against a scan-code-level reference model.
module tb_ps2_keypress_rx;
    localparam int FLEN = 4;
    localparam int TMO  = 400;
    localparam int HP   = 20;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] keycode;
    logic       extended, keypress, key_valid, frame_err;

    int n_asserts = 0;
    int n_fail    = 0;
    int kv_cnt    = 0;
    int fe_cnt    = 0;
    logic kv_q    = 1'b0;
    logic fe_q    = 1'b0;

    // reference model state
    logic [7:0] m_code = 8'h00;
    logic       m_ext = 1'b0, m_press = 1'b0, m_extp = 1'b0, m_brkp = 1'b0;
    int         exp_kv, exp_fe;

    ps2_keypress_rx #(.FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .keycode(keycode), .extended(extended), .keypress(keypress),
        .key_valid(key_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // pulse counting and pulse-shape checks, sampled away from the active edge
    always @(negedge clk) begin
        if (key_valid || frame_err) begin
            chk("kv_fe_exclusive", {31'd0, key_valid && frame_err}, 32'd0);
            chk("pulse_one_cycle", {31'd0, (key_valid && kv_q) || (frame_err && fe_q)}, 32'd0);
        end
        if (key_valid) kv_cnt++;
        if (frame_err) fe_cnt++;
        kv_q = key_valid;
        fe_q = frame_err;
    end

    // Scan-code set 2 rules applied to one received byte (ok=0 means bad frame).
    task automatic ref_byte(input logic [7:0] b, input bit ok);
        exp_kv = 0;
        exp_fe = 0;
        if (!ok) begin
            exp_fe = 1;
            m_extp = 0;
            m_brkp = 0;
        end else if (b == 8'hE0) begin
            m_extp = 1;
        end else if (b == 8'hF0) begin
            m_brkp = 1;
        end else begin
            if (!m_brkp) begin
                m_code = b; m_ext = m_extp; m_press = 1; exp_kv = 1;
            end else if (b == m_code && m_extp == m_ext) begin
                m_press = 0; exp_kv = 1;
            end
            m_extp = 0;
            m_brkp = 0;
        end
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            repeat (HP) @(posedge clk);
            ps2_clk = 1'b0;
            repeat (HP) @(posedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic check_outputs(input string tag, input int kv0, input int fe0);
        chk({tag, ".key_valid_pulses"}, kv_cnt - kv0, exp_kv);
        chk({tag, ".frame_err_pulses"}, fe_cnt - fe0, exp_fe);
        chk({tag, ".keycode"}, {24'd0, keycode}, {24'd0, m_code});
        chk({tag, ".extended"}, {31'd0, extended}, {31'd0, m_ext});
        chk({tag, ".keypress"}, {31'd0, keypress}, {31'd0, m_press});
    endtask

    // One complete frame; par_ok=0 flips parity, stop is the stop-bit level.
    task automatic frame(input string tag, input logic [7:0] b, input bit par_ok, input logic stop);
        int kv0, fe0;
        logic par;
        kv0 = kv_cnt;
        fe0 = fe_cnt;
        par = par_ok ? ~(^b) : (^b);
        ref_byte(b, par_ok && stop);
        send_bits({stop, par, b, 1'b0}, 11);
        repeat (HP) @(posedge clk);
        check_outputs(tag, kv0, fe0);
    endtask

    initial begin
        int kv0, fe0, k;
        logic [7:0] b;
        logic [7:0] codes [4];
        codes[0] = 8'h1D; codes[1] = 8'h1C; codes[2] = 8'h75; codes[3] = 8'h29;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset.keycode", {24'd0, keycode}, 32'h0);
        chk("reset.keypress", {31'd0, keypress}, 32'd0);
        chk("reset.key_valid", {31'd0, key_valid}, 32'd0);
        chk("reset.frame_err", {31'd0, frame_err}, 32'd0);
        reset_n = 1'b1;
        repeat (10) @(posedge clk);

        // make, break of held key, break of non-held key
        frame("make_1d", 8'h1D, 1, 1'b1);
        frame("f0", 8'hF0, 1, 1'b1);
        frame("break_1d", 8'h1D, 1, 1'b1);
        frame("f0b", 8'hF0, 1, 1'b1);
        frame("break_1c_unheld", 8'h1C, 1, 1'b1);

        // extended make/break, then plain 75
        frame("e0", 8'hE0, 1, 1'b1);
        frame("make_e075", 8'h75, 1, 1'b1);
        frame("e0b", 8'hE0, 1, 1'b1);
        frame("f0c", 8'hF0, 1, 1'b1);
        frame("break_e075", 8'h75, 1, 1'b1);
        frame("make_75", 8'h75, 1, 1'b1);
        frame("repeat_75", 8'h75, 1, 1'b1);

        // parity and stop errors; E0 then a parity error must drop the prefix
        frame("bad_parity", 8'h1D, 0, 1'b1);
        frame("bad_stop", 8'h1D, 1, 1'b0);
        frame("e0_pre_err", 8'hE0, 1, 1'b1);
        frame("bad_parity2", 8'h33, 0, 1'b1);
        frame("after_err_make", 8'h1D, 1, 1'b1);

        // timeout after 4 data bits, with a pending E0 that must clear
        frame("e0_pre_tmo", 8'hE0, 1, 1'b1);
        kv0 = kv_cnt; fe0 = fe_cnt;
        send_bits({7'd0, 4'b1010}, 5);
        repeat (TMO + 10) @(posedge clk);
        ref_byte(8'h00, 0);
        check_outputs("timeout", kv0, fe0);
        frame("make_29", 8'h29, 1, 1'b1);

        // sub-filter glitch in IDLE with data low must not start a frame
        kv0 = kv_cnt; fe0 = fe_cnt;
        ps2_data = 1'b0;
        @(posedge clk);
        ps2_clk = 1'b0;
        repeat (FLEN - 1) @(posedge clk);
        ps2_clk = 1'b1;
        repeat (HP) @(posedge clk);
        ps2_data = 1'b1;
        exp_kv = 0; exp_fe = 0;
        check_outputs("glitch", kv0, fe0);
        frame("post_glitch_1c", 8'h1C, 1, 1'b1);

        // asynchronous reset mid-frame
        send_bits({3'b111, 8'h0B}, 5);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_rst.keycode", {24'd0, keycode}, 32'h0);
        chk("async_rst.keypress", {31'd0, keypress}, 32'd0);
        chk("async_rst.extended", {31'd0, extended}, 32'd0);
        m_code = 8'h00; m_ext = 0; m_press = 0; m_extp = 0; m_brkp = 0;
        repeat (5) @(posedge clk);
        reset_n = 1'b1;
        repeat (10) @(posedge clk);
        frame("post_reset_make", 8'h1D, 1, 1'b1);

        // randomized byte stream
        for (int i = 0; i < 30; i++) begin
            k = $urandom_range(0, 9);
            if (k == 0)      b = 8'hE0;
            else if (k == 1) b = 8'hF0;
            else             b = codes[$urandom_range(0, 3)];
            if (k == 2) frame("rand_bad", 8'($urandom), 0, 1'b1);
            else        frame("rand", b, 1, 1'b1);
        end

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    // absolute watchdog so the run always ends
    initial begin
        #5_000_000;
        n_fail++;
        $display("FAIL global_timeout: observed hang expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $fatal(1, "timeout");
    end
endmodule
